// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
// Imported by the bus interface and the timer top.
package countdown_timer_pkg;
  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_PRE_WIDTH = 8;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// master = CPU/MMIO side, slave = timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
);
  logic                 start;
  logic                 stop;
  logic                 periodic;
  logic [WIDTH-1:0]     load_val;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 irq_clr;
  logic [WIDTH-1:0]     val;
  logic                 running;
  logic                 done;
  logic                 expired;
  logic                 irq;

  modport master (
    output start, stop, periodic, load_val, prescale, irq_clr,
    input  val, running, done, expired, irq
  );

  modport slave (
    input  start, stop, periodic, load_val, prescale, irq_clr,
    output val, running, done, expired, irq
  );
endinterface

// File: rtl/countdown_timer_counter.sv
// Wrapping up-counter primitive: counts 0..max while en, top flags count == max.
// reset is a synchronous clear and also serves as the wrap/restart control.
module countdown_timer_counter #(
  parameter int COUNTER_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [COUNTER_LENGTH-1:0] max,
  output logic                      top
);
  localparam logic [COUNTER_LENGTH-1:0] ONE = COUNTER_LENGTH'(1);

  logic [COUNTER_LENGTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == max) ? '0 : count_reg + ONE;
    end
  end

  assign top = (count_reg == max);
endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting timer: prescaled ticks count a latched reload value
// to zero, then pulse expired and set a sticky irq; one-shot or auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  tmr_state_t           state_reg, state_next;
  logic [WIDTH-1:0]     val_reg, val_next;
  logic [WIDTH-1:0]     n_reg, n_next;
  logic [PRE_WIDTH-1:0] p_reg, p_next;
  logic                 periodic_reg, periodic_next;
  logic                 expired_reg, expired_next;
  logic                 irq_reg, irq_next;
  logic                 running;
  logic                 pre_top;
  logic                 tick;
  logic                 pre_clear;

  assign running   = (state_reg == TMR_RUN);
  assign tick      = pre_top & running;
  // Prescaler restarts on any control action and wraps itself on every tick.
  assign pre_clear = reset | bus.start | bus.stop | tick;

  countdown_timer_counter #(
    .COUNTER_LENGTH(PRE_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .reset(pre_clear),
    .en   (running),
    .max  (p_reg),
    .top  (pre_top)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= TMR_IDLE;
      val_reg      <= '0;
      n_reg        <= '0;
      p_reg        <= '0;
      periodic_reg <= 1'b0;
      expired_reg  <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      val_reg      <= val_next;
      n_reg        <= n_next;
      p_reg        <= p_next;
      periodic_reg <= periodic_next;
      expired_reg  <= expired_next;
      irq_reg      <= irq_next;
    end
  end

  // stop beats start, and start beats a tick, so an aborted run never expires.
  always_comb begin
    state_next    = state_reg;
    val_next      = val_reg;
    n_next        = n_reg;
    p_next        = p_reg;
    periodic_next = periodic_reg;
    expired_next  = 1'b0;
    irq_next      = bus.irq_clr ? 1'b0 : irq_reg;

    if (bus.stop) begin
      state_next = TMR_IDLE;
    end else if (bus.start) begin
      state_next    = TMR_RUN;
      val_next      = bus.load_val;
      n_next        = bus.load_val;
      p_next        = bus.prescale;
      periodic_next = bus.periodic;
    end else if (tick) begin
      if (val_reg != '0) begin
        val_next = val_reg - ONE;
      end else begin
        expired_next = 1'b1;
        irq_next     = 1'b1;
        if (periodic_reg) begin
          val_next = n_reg;
        end else begin
          state_next = TMR_DONE;
        end
      end
    end
  end

  assign bus.val     = val_reg;
  assign bus.running = running;
  assign bus.done    = (state_reg == TMR_DONE);
  assign bus.expired = expired_reg;
  assign bus.irq     = irq_reg;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: edge-count reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_countdown_timer;
  localparam int W  = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  countdown_timer_if #(.WIDTH(W), .PRE_WIDTH(PW)) bus ();

  countdown_timer #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks edges elapsed since start; the period is (N+1)*(P+1)
  // and val steps down once every P+1 edges.
  bit     m_ready = 0;
  int     m_mode  = 0;  // 0 idle, 1 running, 2 finished one-shot
  longint m_k, m_n, m_p, m_per;
  longint m_val;
  bit     m_exp, m_irq;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1; m_mode = 0; m_k = 0; m_n = 0; m_p = 0; m_per = 0;
      m_val = 0; m_exp = 0; m_irq = 0;
    end else begin
      bit fire;
      fire  = 0;
      m_exp = 0;
      if (bus.stop) begin
        m_mode = 0;
      end else if (bus.start) begin
        m_mode = 1; m_k = 0;
        m_n = longint'(bus.load_val); m_p = longint'(bus.prescale);
        m_per = longint'(bus.periodic); m_val = m_n;
      end else if (m_mode == 1) begin
        m_k++;
        if (m_k == (m_n + 1) * (m_p + 1)) begin
          fire = 1; m_exp = 1;
          if (m_per != 0) begin
            m_k = 0; m_val = m_n;
          end else begin
            m_mode = 2; m_val = 0;
          end
        end else begin
          m_val = m_n - m_k / (m_p + 1);
        end
      end
      if (fire) m_irq = 1;
      else if (bus.irq_clr) m_irq = 0;
    end
  end

  task automatic cmp(input string name, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m_ready) begin
      cmp("model_val",     longint'(bus.val),     m_val & 64'hFFFF);
      cmp("model_running", longint'(bus.running), longint'(m_mode == 1));
      cmp("model_done",    longint'(bus.done),    longint'(m_mode == 2));
      cmp("model_expired", longint'(bus.expired), longint'(m_exp));
      cmp("model_irq",     longint'(bus.irq),     longint'(m_irq));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the sampling edge (edge 0).
  task automatic do_start(input logic [W-1:0] n, input logic [PW-1:0] p, input logic per);
    bus.start = 1'b1; bus.load_val = n; bus.prescale = p; bus.periodic = per;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1'b1;
    step(1);
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    int vseq [6];
    int cnt;
    vseq = '{2, 1, 0, 2, 1, 0};

    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.periodic = 0; bus.load_val = '0;
    bus.prescale = '0; bus.irq_clr = 0;
    step(3);
    reset = 1'b0;
    cmp("rst_val", bus.val, 0);
    cmp("rst_running", bus.running, 0);
    $display("txn reset: val=%0d running=%0d", bus.val, bus.running);

    // 1: reset mid-run
    do_start(16'd10, 8'd0, 1'b0);
    step(3);
    cmp("t1_running_before", bus.running, 1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    cmp("t1_val", bus.val, 0);
    cmp("t1_running", bus.running, 0);
    cmp("t1_irq", bus.irq, 0);
    cmp("t1_expired", bus.expired, 0);
    $display("txn reset_mid_run: val=%0d running=%0d irq=%0d", bus.val, bus.running, bus.irq);

    // 2: one-shot N=3 P=1, expiry 8 edges after start
    do_start(16'd3, 8'd1, 1'b0);
    step(7);
    cmp("t2_exp_edge7", bus.expired, 0);
    step(1);
    cmp("t2_exp_edge8", bus.expired, 1);
    cmp("t2_done", bus.done, 1);
    cmp("t2_val", bus.val, 0);
    cmp("t2_irq", bus.irq, 1);
    step(1);
    cmp("t2_exp_edge9", bus.expired, 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.expired) cnt++;
    end
    cmp("t2_no_repeat", cnt, 0);
    $display("txn oneshot: done=%0d val=%0d irq=%0d extra_pulses=%0d", bus.done, bus.val, bus.irq, cnt);

    // 3: periodic N=2 P=0
    clear_irq();
    do_start(16'd2, 8'd0, 1'b1);
    cmp("t3_val_e0", bus.val, vseq[0]);
    for (int e = 1; e <= 12; e++) begin
      step(1);
      cmp($sformatf("t3_exp_e%0d", e), bus.expired, (e % 3 == 0) ? 1 : 0);
      if (e <= 5) cmp($sformatf("t3_val_e%0d", e), bus.val, vseq[e]);
    end
    $display("txn periodic: running=%0d irq=%0d", bus.running, bus.irq);
    do_stop();

    // 4a: N=0 P=0 periodic -> pulse every edge
    do_start(16'd0, 8'd0, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      step(1);
      cmp($sformatf("t4a_exp_e%0d", e), bus.expired, 1);
      cmp($sformatf("t4a_val_e%0d", e), bus.val, 0);
    end
    $display("txn every_edge: expired=%0d", bus.expired);
    do_stop();

    // 5: restart at edge 5 of an N=3 P=1 run
    do_start(16'd3, 8'd1, 1'b0);
    step(4);
    do_start(16'd3, 8'd1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1);
      cmp($sformatf("t5_exp_e%0d", e + 5), bus.expired, (e == 8) ? 1 : 0);
    end
    $display("txn restart: done=%0d", bus.done);

    // 5b: stop and start together -> stop wins, val holds
    do_start(16'd3, 8'd1, 1'b1);
    step(3);
    cmp("t5b_val_before", bus.val, 2);
    bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 16'd9;
    step(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    cmp("t5b_running", bus.running, 0);
    cmp("t5b_done", bus.done, 0);
    cmp("t5b_val", bus.val, 2);
    step(3);
    cmp("t5b_val_later", bus.val, 2);
    $display("txn stop_start: running=%0d val=%0d", bus.running, bus.val);

    // 6: irq_clr coincident with expiry loses; one cycle later it clears
    clear_irq();
    do_start(16'd1, 8'd0, 1'b0);
    step(1);
    cmp("t6_exp_e1", bus.expired, 0);
    bus.irq_clr = 1'b1;
    step(1);
    bus.irq_clr = 1'b0;
    cmp("t6_exp_e2", bus.expired, 1);
    cmp("t6_irq_set_wins", bus.irq, 1);
    bus.irq_clr = 1'b1;
    step(1);
    bus.irq_clr = 1'b0;
    cmp("t6_irq_cleared", bus.irq, 0);
    $display("txn irq_clr: irq=%0d", bus.irq);

    // 4b: N=max P=0 -> first expiry 2^WIDTH edges after start
    do_start(16'hFFFF, 8'd0, 1'b0);
    cnt = 0;
    while (!bus.expired && cnt < 70000) begin
      step(1);
      cnt++;
    end
    cmp("t4b_first_expiry", cnt, 65536);
    $display("txn max_count: edges=%0d", cnt);

    step(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
